mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 44 ++++
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: opcode and funct3 encodings, FSM state type.
// Also holds the byte-enable base mask helper used by the lane aligner.
package mem_stage_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Unshifted byte enables for an access of the size in funct3[1:0].
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store data replication, load extract and extend.
// Lanes shifted past byte 7 are simply dropped.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  byte_off,
  input  logic [63:0] st_data,
  input  logic [63:0] rd_data,
  output logic [7:0]  byte_en,
  output logic [63:0] wr_data,
  output logic [63:0] ld_data
);

  logic [63:0] rd_shift;

  assign rd_shift = rd_data >> {byte_off, 3'b000};
  assign byte_en  = size_mask(funct3[1:0]) << byte_off;

  always_comb begin
    wr_data = st_data;
    case (funct3[1:0])
      2'b00:   wr_data = {8{st_data[7:0]}};
      2'b01:   wr_data = {4{st_data[15:0]}};
      2'b10:   wr_data = {2{st_data[31:0]}};
      default: wr_data = st_data;
    endcase
  end

  always_comb begin
    ld_data = rd_shift;
    case (funct3)
      F3_B:    ld_data = {{56{rd_shift[7]}}, rd_shift[7:0]};
      F3_H:    ld_data = {{48{rd_shift[15]}}, rd_shift[15:0]};
      F3_W:    ld_data = {{32{rd_shift[31]}}, rd_shift[31:0]};
      F3_D:    ld_data = rd_shift;
      F3_BU:   ld_data = {56'h0, rd_shift[7:0]};
      F3_HU:   ld_data = {48'h0, rd_shift[15:0]};
      F3_WU:   ld_data = {32'h0, rd_shift[31:0]};
      default: ld_data = rd_shift;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: data-memory handshake with ack timeout, branch redirect, writeback latch.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned accesses into exceptions instead of bus requests.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_V,
  input  logic        MEM_PC_MUX,
  input  logic [63:0] MEM_RES,
  input  logic [63:0] MEM_Address,
  input  logic [63:0] MEM_NPC,
  input  logic [63:0] MEM_Target_Address,
  input  logic [31:0] MEM_IR,
  input  logic [16:0] MEM_Cst,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [63:0] DMEM_ADDR,
  output logic [63:0] DMEM_WDATA,
  output logic [7:0]  DMEM_BE,
  input  logic [63:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        MEM_STALL,
  output logic        MEM_BR_TAKEN,
  output logic [63:0] MEM_BR_TARGET,
  output logic        WB_V,
  output logic        WB_EXC,
  output logic [63:0] WB_RES,
  output logic [63:0] WB_NPC,
  output logic [31:0] WB_IR,
  output logic [4:0]  WB_DR
);

  mem_state_e  state, state_nxt;
  logic [15:0] wait_cnt;
  logic [4:0]  opcode;
  logic        is_load, is_store, mem_op, access, trap, exc;
  logic        req, timeout;
  logic [63:0] ld_data;
  logic        cst_unused;

  assign cst_unused = ^MEM_Cst;
  assign opcode     = MEM_IR[6:2];
  assign is_load    = (opcode == OP_LOAD);
  assign is_store   = (opcode == OP_STORE);
  assign mem_op     = MEM_V & (is_load | is_store);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (MEM_IR[13:12])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = MEM_Address[0];
      2'b10:   misaligned = |MEM_Address[1:0];
      default: misaligned = |MEM_Address[2:0];
    endcase
  end
  assign trap = mem_op & misaligned;
`else
  assign trap = 1'b0;
`endif

  assign access = mem_op & ~trap;
  assign exc    = timeout | trap;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          req = 1'b1;
          if (!DMEM_ACK) state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (DMEM_ACK) begin
          req       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == 16'(ACK_TIMEOUT)) begin
          // Abandon the access: release the pipeline with an exception.
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          req = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 16'h0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && state_nxt == ST_WAIT) wait_cnt <= wait_cnt + 16'd1;
      else                                          wait_cnt <= 16'h0;
    end
  end

  // Reset gates the request directly so it drops without waiting for a clock.
  assign DMEM_REQ  = req & ~RESET;
  assign DMEM_WE   = req & is_store & ~RESET;
  assign MEM_STALL = req & ~DMEM_ACK & ~RESET;
  assign DMEM_ADDR = {MEM_Address[63:3], 3'b000};

  mem_lane_align u_align (
    .funct3   (MEM_IR[14:12]),
    .byte_off (MEM_Address[2:0]),
    .st_data  (MEM_RES),
    .rd_data  (DMEM_RDATA),
    .byte_en  (DMEM_BE),
    .wr_data  (DMEM_WDATA),
    .ld_data  (ld_data)
  );

  assign MEM_BR_TAKEN  = MEM_V & (((opcode == OP_BRANCH) & MEM_PC_MUX) |
                                  (opcode == OP_JAL) | (opcode == OP_JALR));
  assign MEM_BR_TARGET = MEM_Target_Address;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WB_V   <= 1'b0;
      WB_EXC <= 1'b0;
      WB_RES <= 64'h0;
      WB_NPC <= 64'h0;
      WB_IR  <= 32'h0;
      WB_DR  <= 5'h0;
    end else if (MEM_STALL) begin
      WB_V <= 1'b0;
    end else begin
      WB_V   <= MEM_V | exc;
      WB_EXC <= exc;
      WB_RES <= (is_load && !exc) ? ld_data : MEM_RES;
      WB_NPC <= MEM_NPC;
      WB_IR  <= MEM_IR;
      WB_DR  <= MEM_IR[11:7];
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, randomized accesses vs a byte-level model,
// and hand sequences for stall, timeout, branch and reset corner cases.
module tb_mem_stage;

  localparam int TO = 4;
  localparam logic [4:0] T_LOAD  = 5'b00000;
  localparam logic [4:0] T_STORE = 5'b01000;
  localparam logic [4:0] T_ALU   = 5'b01100;
  localparam logic [4:0] T_BR    = 5'b11000;
  localparam logic [4:0] T_JAL   = 5'b11011;
  localparam logic [4:0] T_JALR  = 5'b11001;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_V, MEM_PC_MUX;
  logic [63:0] MEM_RES, MEM_Address, MEM_NPC, MEM_Target_Address;
  logic [31:0] MEM_IR;
  logic [16:0] MEM_Cst;
  logic        DMEM_REQ, DMEM_WE;
  logic [63:0] DMEM_ADDR, DMEM_WDATA;
  logic [7:0]  DMEM_BE;
  logic [63:0] DMEM_RDATA;
  logic        DMEM_ACK;
  logic        MEM_STALL, MEM_BR_TAKEN;
  logic [63:0] MEM_BR_TARGET;
  logic        WB_V, WB_EXC;
  logic [63:0] WB_RES, WB_NPC;
  logic [31:0] WB_IR;
  logic [4:0]  WB_DR;

  int tests = 0;
  int fails = 0;
  logic [63:0] cur_npc;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_PC_MUX(MEM_PC_MUX),
    .MEM_RES(MEM_RES), .MEM_Address(MEM_Address), .MEM_NPC(MEM_NPC),
    .MEM_Target_Address(MEM_Target_Address), .MEM_IR(MEM_IR), .MEM_Cst(MEM_Cst),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_ACK(DMEM_ACK), .MEM_STALL(MEM_STALL), .MEM_BR_TAKEN(MEM_BR_TAKEN),
    .MEM_BR_TARGET(MEM_BR_TARGET), .WB_V(WB_V), .WB_EXC(WB_EXC), .WB_RES(WB_RES),
    .WB_NPC(WB_NPC), .WB_IR(WB_IR), .WB_DR(WB_DR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] res;
    logic [63:0] rdata;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] wbres;
  } vec_t;

  vec_t tbl [8];

  typedef struct {
    logic       v;
    logic [4:0] op;
    logic       pcmux;
    logic       taken;
  } br_t;

  br_t brt [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] m_be(input logic [2:0] f3, input int off);
    logic [15:0] v;
    v = ((16'd1 << nbytes(f3)) - 16'd1) << off;
    return v[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [2:0] f3, input logic [63:0] res);
    logic [63:0] w;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = res[(i % n)*8 +: 8];
    return w;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input int off, input logic [63:0] rd);
    logic [63:0] v, mask;
    int n;
    n = nbytes(f3);
    v = rd >> (8 * off);
    if (n < 8) begin
      mask = (64'd1 << (8 * n)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, op, 2'b11};
  endfunction

  task automatic drive(input logic [4:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] addr, input logic [63:0] res,
                       input logic [63:0] rdata, input logic ack);
    MEM_V       = 1'b1;
    MEM_IR      = mk_ir(op, f3, rd);
    MEM_Address = addr;
    MEM_RES     = res;
    DMEM_RDATA  = rdata;
    DMEM_ACK    = ack;
    MEM_PC_MUX  = 1'b0;
    cur_npc     = {$urandom, $urandom};
    MEM_NPC     = cur_npc;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    bit done;
    logic [63:0] rd64;

    tbl[0] = '{T_LOAD,  3'b011, 64'h1000, 64'h0, 64'h1122334455667788, 8'hFF, 64'h0, 64'h1122334455667788};
    tbl[1] = '{T_LOAD,  3'b000, 64'h1003, 64'h0, 64'h0000000080000000, 8'h08, 64'h0, 64'hFFFFFFFFFFFFFF80};
    tbl[2] = '{T_LOAD,  3'b100, 64'h1003, 64'h0, 64'h0000000080000000, 8'h08, 64'h0, 64'h0000000000000080};
    tbl[3] = '{T_LOAD,  3'b001, 64'h1006, 64'h0, 64'h8001000000000000, 8'hC0, 64'h0, 64'hFFFFFFFFFFFF8001};
    tbl[4] = '{T_LOAD,  3'b110, 64'h1004, 64'h0, 64'hF000000100000000, 8'hF0, 64'h0, 64'h00000000F0000001};
    tbl[5] = '{T_STORE, 3'b010, 64'h3004, 64'h12345678, 64'h0, 8'hF0, 64'h1234567812345678, 64'h12345678};
    tbl[6] = '{T_STORE, 3'b000, 64'h3007, 64'h1A5, 64'h0, 8'h80, 64'hA5A5A5A5A5A5A5A5, 64'h1A5};
    tbl[7] = '{T_STORE, 3'b011, 64'h3000, 64'hDEADBEEFCAFEF00D, 64'h0, 8'hFF, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D};

    brt[0] = '{1'b1, T_BR,   1'b1, 1'b1};
    brt[1] = '{1'b0, T_BR,   1'b1, 1'b0};
    brt[2] = '{1'b1, T_BR,   1'b0, 1'b0};
    brt[3] = '{1'b1, T_JAL,  1'b0, 1'b1};
    brt[4] = '{1'b1, T_JALR, 1'b0, 1'b1};

    RESET = 1'b1; MEM_V = 0; MEM_PC_MUX = 0; MEM_RES = 0; MEM_Address = 0; MEM_NPC = 0;
    MEM_Target_Address = 0; MEM_IR = 0; MEM_Cst = 0; DMEM_RDATA = 0; DMEM_ACK = 0; cur_npc = 0;

    #12;
    check("rst_wb_v", WB_V, 0);
    check("rst_wb_exc", WB_EXC, 0);
    check("rst_wb_res", WB_RES, 0);
    check("rst_wb_npc", WB_NPC, 0);
    check("rst_wb_ir", WB_IR, 0);
    check("rst_wb_dr", WB_DR, 0);
    check("rst_req", DMEM_REQ, 0);
    @(negedge CLK);
    RESET = 1'b0;
    tick();

    // Directed vectors, all acked in the same cycle.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].op, tbl[i].f3, 5'(i + 1), tbl[i].addr, tbl[i].res, tbl[i].rdata, 1'b1);
      @(negedge CLK);
      check($sformatf("vec%0d_req", i), DMEM_REQ, 1);
      check($sformatf("vec%0d_stall", i), MEM_STALL, 0);
      check($sformatf("vec%0d_addr", i), DMEM_ADDR, {tbl[i].addr[63:3], 3'b000});
      check($sformatf("vec%0d_be", i), DMEM_BE, tbl[i].be);
      check($sformatf("vec%0d_we", i), DMEM_WE, tbl[i].op == T_STORE);
      if (tbl[i].op == T_STORE) check($sformatf("vec%0d_wdata", i), DMEM_WDATA, tbl[i].wdata);
      tick();
      check($sformatf("vec%0d_wb_v", i), WB_V, 1);
      check($sformatf("vec%0d_wb_res", i), WB_RES, tbl[i].wbres);
      check($sformatf("vec%0d_wb_dr", i), WB_DR, 5'(i + 1));
      check($sformatf("vec%0d_wb_npc", i), WB_NPC, cur_npc);
      check($sformatf("vec%0d_wb_exc", i), WB_EXC, 0);
    end

    // Randomized aligned accesses against the byte-level model.
    for (int i = 0; i < 60; i++) begin
      int kind, n, off;
      logic [2:0] f3;
      logic [4:0] op, rd;
      logic [63:0] addr, res;
      logic v, is_mem;
      kind = $urandom_range(0, 2);
      op   = (kind == 0) ? T_LOAD : (kind == 1) ? T_STORE : T_ALU;
      f3   = (kind == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      n    = nbytes(f3);
      off  = ($urandom_range(0, 7) / n) * n;
      addr = {$urandom, $urandom};
      addr[2:0] = 3'(off);
      res  = {$urandom, $urandom};
      rd64 = {$urandom, $urandom};
      rd   = 5'($urandom_range(0, 31));
      v    = ($urandom_range(0, 3) != 0);
      drive(op, f3, rd, addr, res, rd64, 1'b1);
      MEM_V = v;
      is_mem = v && (kind != 2);
      @(negedge CLK);
      check("rnd_req", DMEM_REQ, is_mem);
      check("rnd_stall", MEM_STALL, 0);
      if (is_mem) check("rnd_be", DMEM_BE, m_be(f3, off));
      if (is_mem && kind == 1) check("rnd_wdata", DMEM_WDATA, m_wdata(f3, res));
      tick();
      check("rnd_wb_v", WB_V, v);
      if (v) check("rnd_wb_res", WB_RES, (kind == 0) ? m_load(f3, off, rd64) : res);
      if (v) check("rnd_wb_dr", WB_DR, rd);
    end

    // SH with ack after three stalled cycles.
    drive(T_STORE, 3'b001, 5'd3, 64'h2006, 64'hABCD, 64'h0, 1'b0);
    stall_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (MEM_STALL) stall_cnt++;
      check("sh_req_hold", DMEM_REQ, 1);
      check("sh_be_hold", DMEM_BE, 8'hC0);
      check("sh_wdata_hold", DMEM_WDATA, 64'hABCDABCDABCDABCD);
      check("sh_addr_hold", DMEM_ADDR, 64'h2000);
      tick();
      check("sh_wb_v_stall", WB_V, 0);
    end
    DMEM_ACK = 1'b1;
    @(negedge CLK);
    check("sh_stall_on_ack", MEM_STALL, 0);
    tick();
    check("sh_stall_cycles", stall_cnt, 3);
    check("sh_wb_v", WB_V, 1);
    check("sh_wb_res", WB_RES, 64'hABCD);

    // Load never acked: timeout exception after ACK_TIMEOUT waiting cycles.
    drive(T_LOAD, 3'b011, 5'd4, 64'h5000, 64'h77, 64'h1234, 1'b0);
    stall_cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (MEM_STALL) stall_cnt++;
      else done = 1'b1;
      tick();
    end
    check("to_released", done, 1);
    check("to_stall_cycles", stall_cnt, 1 + TO);
    check("to_wb_v", WB_V, 1);
    check("to_wb_exc", WB_EXC, 1);
    MEM_V = 1'b0;
    DMEM_ACK = 1'b1;
    @(negedge CLK);
    check("stray_ack_req", DMEM_REQ, 0);
    check("stray_ack_stall", MEM_STALL, 0);
    tick();
    check("stray_ack_wb_v", WB_V, 0);
    check("stray_ack_wb_exc", WB_EXC, 0);
    drive(T_LOAD, 3'b011, 5'd5, 64'h6000, 64'h0, 64'hCAFE0000BEEF0001, 1'b1);
    @(negedge CLK);
    check("post_to_stall", MEM_STALL, 0);
    check("post_to_req", DMEM_REQ, 1);
    tick();
    check("post_to_wb_res", WB_RES, 64'hCAFE0000BEEF0001);

    // Branch redirect.
    for (int i = 0; i < 5; i++) begin
      logic [63:0] tgt;
      drive(brt[i].op, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 1'b0);
      MEM_V = brt[i].v;
      MEM_PC_MUX = brt[i].pcmux;
      tgt = (i == 0) ? 64'h4000 : {$urandom, $urandom};
      MEM_Target_Address = tgt;
      @(negedge CLK);
      check($sformatf("br%0d_taken", i), MEM_BR_TAKEN, brt[i].taken);
      check($sformatf("br%0d_target", i), MEM_BR_TARGET, tgt);
      check($sformatf("br%0d_stall", i), MEM_STALL, 0);
      tick();
    end

    // Reset while waiting on an ack.
    drive(T_LOAD, 3'b011, 5'd6, 64'h7000, 64'h0, 64'h55, 1'b0);
    @(negedge CLK);
    check("wait_stall", MEM_STALL, 1);
    tick();
    #2;
    RESET = 1'b1;
    DMEM_ACK = 1'b1;
    #1;
    check("rst_wait_req", DMEM_REQ, 0);
    check("rst_wait_stall", MEM_STALL, 0);
    check("rst_wait_wb_v", WB_V, 0);
    tick();
    check("rst_wait_wb_res", WB_RES, 0);
    check("rst_wait_wb_npc", WB_NPC, 0);
    @(negedge CLK);
    MEM_V = 1'b0;
    DMEM_ACK = 1'b0;
    RESET = 1'b0;
    #1;
    check("rst_rel_req", DMEM_REQ, 0);
    tick();
    check("rst_rel_wb_v", WB_V, 0);

    // Misaligned LW.
    rd64 = 64'h0000_8765_4321_0000;
    drive(T_LOAD, 3'b010, 5'd7, 64'h1002, 64'h0, rd64, 1'b1);
    @(negedge CLK);
`ifdef MEM_MISALIGN_TRAP_EN
    check("mis_req", DMEM_REQ, 0);
    check("mis_stall", MEM_STALL, 0);
    tick();
    check("mis_wb_v", WB_V, 1);
    check("mis_wb_exc", WB_EXC, 1);
`else
    check("mis_req", DMEM_REQ, 1);
    check("mis_be", DMEM_BE, m_be(3'b010, 2));
    tick();
    check("mis_wb_v", WB_V, 1);
    check("mis_wb_exc", WB_EXC, 0);
    check("mis_wb_res", WB_RES, m_load(3'b010, 2, rd64));
`endif
    MEM_V = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
